fifo_stream_reader: RTL and testbench

- Read-side engine for the team's Sync_FIFO: drains words via r_en/empty/data_out and presents them on a valid/ready stream.
- Converts the FIFO's registered read (data one cycle after r_en) into a first-word-fall-through stream with full throughput.
- Sits between Sync_FIFO and any downstream consumer, and also provides a delivered-word counter and a synchronous flush.

---
 rtl/fifo_stream_reader_if.sv | 30 +++
 rtl/fifo_stream_reader.sv | 81 ++++++++
 tb/tb_fifo_stream_reader.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
// Read-side FIFO port plus outgoing valid/ready stream
// for fifo_stream_reader.
interface fifo_stream_reader_if #(
  parameter int Width = 8
);
  logic             fifo_empty;
  logic             fifo_r_en;
  logic [Width-1:0] fifo_data_out;
  logic             m_valid;
  logic [Width-1:0] m_data;
  logic             m_ready;

  modport master (
    input  fifo_empty,
    input  fifo_data_out,
    input  m_ready,
    output fifo_r_en,
    output m_valid,
    output m_data
  );

  modport slave (
    output fifo_empty,
    output fifo_data_out,
    output m_ready,
    input  fifo_r_en,
    input  m_valid,
    input  m_data
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a registered-read Sync_FIFO into a first-word-fall-through
// valid/ready stream with a 3-deep skid buffer and flush.
module fifo_stream_reader #(
  parameter int Width = 8,
  parameter int CntW  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_stream_reader_if.master  bus,
  input  logic                  flush,
  output logic [CntW-1:0]       rd_count,
  output logic                  busy
);

  logic [Width-1:0] buf_q [3];
  logic [Width-1:0] buf_d [3];
  logic [1:0]       buf_cnt;
  logic [1:0]       cnt_d;
  logic             inflight;
  logic [2:0]       occ;
  logic             r_en;
  logic             m_valid;
  logic             pop;
  logic             cap;

  assign m_valid = (buf_cnt != 2'd0);
  assign pop     = m_valid && bus.m_ready && !flush;
  assign cap     = inflight && !flush;
  assign occ     = {1'b0, buf_cnt} + {2'b00, inflight};

  // Slots are reserved when the read is issued, so the buffer
  // can never overflow and m_ready never reaches r_en.
  assign r_en = !rst && !bus.fifo_empty && !flush
             && (occ < 3'd3);

  assign bus.fifo_r_en = r_en;
  assign bus.m_valid   = m_valid;
  assign bus.m_data    = buf_q[0];
  assign busy          = m_valid || inflight;

  // Unused slots are kept at zero so an empty head reads as 0.
  always_comb begin
    buf_d = buf_q;
    cnt_d = buf_cnt;
    if (pop) begin
      buf_d[0] = buf_q[1];
      buf_d[1] = buf_q[2];
      buf_d[2] = '0;
      cnt_d    = buf_cnt - 2'd1;
    end
    if (cap) begin
      case (cnt_d)
        2'd0:    buf_d[0] = bus.fifo_data_out;
        2'd1:    buf_d[1] = bus.fifo_data_out;
        2'd2:    buf_d[2] = bus.fifo_data_out;
        default: ;
      endcase
      cnt_d = cnt_d + 2'd1;
    end
    if (flush) begin
      buf_d = '{default: '0};
      cnt_d = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q    <= '{default: '0};
      buf_cnt  <= 2'd0;
      inflight <= 1'b0;
      rd_count <= '0;
    end else begin
      buf_q    <= buf_d;
      buf_cnt  <= cnt_d;
      inflight <= r_en;
      if (pop)
        rd_count <= rd_count + CntW'(1);
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader against a
// behavioural registered-read FIFO.
module tb_fifo_stream_reader;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        rdy = 1'b0;
  logic [15:0] rd_count;
  logic        busy;

  fifo_stream_reader_if #(.Width(W)) bus ();

  fifo_stream_reader #(.Width(W), .CntW(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.master),
    .flush    (flush),
    .rd_count (rd_count),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Behavioural Sync_FIFO: data appears the cycle after r_en.
  logic [7:0] mem [256];
  int         wcnt = 0;
  int         rcnt = 0;
  logic [7:0] fdo = 8'h00;

  assign bus.fifo_empty    = (wcnt == rcnt);
  assign bus.fifo_data_out = fdo;
  assign bus.m_ready       = rdy;

  always @(posedge clk) begin
    if (bus.fifo_r_en) begin
      fdo  <= mem[rcnt];
      rcnt <= rcnt + 1;
    end
  end

  logic [7:0] got [$];
  int         got_cyc [$];
  int         cyc = 0;
  int         viol = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && bus.m_valid && rdy && !flush) begin
      got.push_back(bus.m_data);
      got_cyc.push_back(cyc);
    end
    if (bus.fifo_r_en && bus.fifo_empty)
      viol <= viol + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    mem[wcnt] = v;
    wcnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_words(input string name, input int base,
                            input int n, input int lim);
    for (int k = 0; k < lim && got.size() - base < n; k++)
      @(negedge clk);
    chk(name, got.size() - base, n);
  endtask

  typedef struct {
    logic        rdy;
    logic        r_en;
    logic        valid;
    logic [7:0]  data;
    logic        busy;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int base;
    int pulses;
    int unstable;
    int bad;
    int vcnt;
    int first;
    int n;
    logic [7:0] vdat;
    logic [7:0] hold;
    logic [7:0] exp16 [16];
    logic pv;
    logic pr;
    logic [7:0] pd;
    logic found;

    tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 16'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 16'd0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 8'h02, 1'b1, 16'd1};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 8'h04, 1'b1, 16'd2};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 8'h06, 1'b1, 16'd3};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 8'h08, 1'b1, 16'd4};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd5};

    // Basic latency / throughput, preloaded during reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.m_valid, 1'b0);
    chk("rst_r_en", bus.fifo_r_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    for (int i = 0; i < 5; i++)
      push(8'(2 * i));
    rdy = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0)
        @(negedge clk);
      rdy = tbl[i].rdy;
      #1;
      chk($sformatf("r_en[%0d]", i), bus.fifo_r_en, tbl[i].r_en);
      chk($sformatf("valid[%0d]", i), bus.m_valid, tbl[i].valid);
      chk($sformatf("data[%0d]", i), bus.m_data, tbl[i].data);
      chk($sformatf("busy[%0d]", i), busy, tbl[i].busy);
      chk($sformatf("cnt[%0d]", i), rd_count, tbl[i].cnt);
    end

    // Backpressure: buffer fills to 3 then reads stop
    @(negedge clk);
    rdy = 1'b0;
    do_reset();
    base = got.size();
    for (int i = 0; i < 10; i++)
      push(8'(2 * i));
    pulses = 0;
    unstable = 0;
    hold = 8'h00;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.fifo_r_en)
        pulses++;
      if (bus.m_valid && bus.m_data !== hold)
        unstable++;
      @(negedge clk);
    end
    chk("bp_pulses", pulses, 3);
    chk("bp_buf_cnt", dut.buf_cnt, 2'd3);
    chk("bp_valid", bus.m_valid, 1'b1);
    chk("bp_data", bus.m_data, 8'h00);
    chk("bp_stable", unstable, 0);
    rdy = 1'b1;
    wait_words("bp_timeout", base, 10, 40);
    for (int k = 0; k < 10 && base + k < got.size(); k++)
      chk($sformatf("bp_word[%0d]", k), got[base + k], 8'(2 * k));
    if (got.size() - base >= 10)
      chk("bp_gap", got_cyc[base + 9] - got_cyc[base], 9);
    chk("bp_rd_count", rd_count, 16'd10);

    // Empty boundary, then one lone word
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (bus.fifo_r_en || bus.m_valid)
        bad++;
    end
    chk("empty_idle", bad, 0);
    @(negedge clk);
    push(8'h55);
    vcnt = 0;
    vdat = 8'h00;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.m_valid) begin
        vcnt++;
        vdat = bus.m_data;
      end
      @(negedge clk);
    end
    chk("single_cycles", vcnt, 1);
    chk("single_data", vdat, 8'h55);

    // Random m_ready over 16 words
    do_reset();
    base = got.size();
    for (int i = 0; i < 16; i++) begin
      exp16[i] = 8'($urandom_range(0, 255));
      push(exp16[i]);
    end
    pv = 1'b0;
    pr = 1'b0;
    pd = 8'h00;
    unstable = 0;
    for (int k = 0; k < 300 && got.size() - base < 16; k++) begin
      if (pv && !pr && (!bus.m_valid || bus.m_data !== pd))
        unstable++;
      pv = bus.m_valid;
      pd = bus.m_data;
      rdy = 1'($urandom_range(0, 1));
      pr = rdy;
      @(negedge clk);
    end
    rdy = 1'b1;
    chk("rnd_timeout", got.size() - base, 16);
    for (int k = 0; k < 16 && base + k < got.size(); k++)
      chk($sformatf("rnd_word[%0d]", k), got[base + k], exp16[k]);
    chk("rnd_rd_count", rd_count, 16'd16);
    chk("rnd_stable", unstable, 0);
    chk("r_en_while_empty", viol, 0);

    // Flush with buf_cnt=2 and a read in flight
    rdy = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++)
      push(8'(8'hA0 + i));
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (dut.buf_cnt == 2'd2 && dut.inflight)
        found = 1'b1;
      else
        @(negedge clk);
    end
    chk("fl_setup", found, 1'b1);
    base = got.size();
    flush = 1'b1;
    rdy = 1'b1;
    #1;
    chk("fl_r_en", bus.fifo_r_en, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    chk("fl_valid", bus.m_valid, 1'b0);
    chk("fl_rd_count", rd_count, 16'd0);
    wait_words("fl_timeout", base, 2, 20);
    if (got.size() - base >= 2) begin
      chk("fl_first", got[base], 8'hA3);
      chk("fl_second", got[base + 1], 8'hA4);
    end
    repeat (4) @(negedge clk);
    chk("fl_no_extra", got.size() - base, 2);
    chk("fl_cnt_after", rd_count, 16'd2);
    chk("fl_busy", busy, 1'b0);

    // Async reset mid-stream
    base = got.size();
    for (int i = 0; i < 6; i++)
      push(8'(8'hC0 + i));
    wait_words("ar_timeout", base, 2, 20);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_outs", {bus.m_valid, bus.m_data, rd_count,
                    busy, bus.fifo_r_en}, 27'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    base = got.size();
    first = rcnt;
    for (int i = 6; i < 9; i++)
      push(8'(8'hC0 + i));
    n = wcnt - first;
    wait_words("ar_restart", base, n, 40);
    for (int k = 0; k < n && base + k < got.size(); k++)
      chk($sformatf("ar_word[%0d]", k), got[base + k],
          mem[first + k]);
    chk("ar_rd_count", rd_count, 16'(n));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
